fir_decim_fifo: RTL and testbench

FIR_DECIM_FIFO -- requirements
Module: fir_decim_fifo

---
 rtl/fir_decim_fifo.sv | 132 +++++++++++++
 tb/tb_fir_decim_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_fifo.sv
// Decimator behind an upstream FIR stage: keeps or averages every DECIM-sample group
// and queues the result in a DEPTH-entry FIFO with a sticky overflow flag.
module fir_decim_fifo #(
    parameter int DW    = 8,
    parameter int DECIM = 4,
    parameter int MODE  = 0,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            inp,
    input  logic                     in_valid,
    output logic [DW-1:0]            outp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    input  logic                     clr_ovf
);

    localparam int LD   = $clog2(DECIM);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int ACCW = DW + LD;

    logic [LD-1:0]   phase_r;
    logic [ACCW-1:0] acc_r;
    logic [DW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            out_valid_r;
    logic [DW-1:0]   outp_r;
    logic            ovf_r;

    logic [ACCW-1:0] inp_ext_s;
    logic [ACCW-1:0] sum_s;
    logic            phase_last_s;
    logic            dec_valid_s;
    logic [DW-1:0]   dec_data_s;
    logic            pop_s;
    logic            full_s;
    logic            push_s;
    logic            drop_s;
    logic [CW-1:0]   count_nxt_s;
    logic [AW-1:0]   rd_ptr_nxt_s;
    logic [DW-1:0]   head_nxt_s;

    // Decimation datapath and FIFO push/pop/drop decisions
    always_comb begin
        inp_ext_s    = {{LD{inp[DW-1]}}, inp};
        sum_s        = acc_r + inp_ext_s;
        phase_last_s = (phase_r == LD'(DECIM - 1));
        if (MODE == 1) begin
            dec_valid_s = in_valid && phase_last_s;
            // Dropping the low LD bits is an arithmetic shift that floors toward -inf
            dec_data_s  = sum_s[ACCW-1:LD];
        end else begin
            dec_valid_s = in_valid && (phase_r == {LD{1'b0}});
            dec_data_s  = inp;
        end
        pop_s  = out_valid_r && out_ready;
        full_s = (count_r == CW'(DEPTH));
        push_s = dec_valid_s && (!full_s || pop_s);
        drop_s = dec_valid_s && full_s && !pop_s;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
        // A push into an (effectively) empty FIFO becomes the head directly
        if (push_s && (count_r == CW'(pop_s))) begin
            head_nxt_s = dec_data_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Phase counter and group accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r <= {LD{1'b0}};
            acc_r   <= {ACCW{1'b0}};
        end else if (in_valid) begin
            phase_r <= phase_last_s ? {LD{1'b0}} : phase_r + LD'(1'b1);
            acc_r   <= (phase_r == {LD{1'b0}}) ? inp_ext_s : sum_s;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= dec_data_s;
        end
    end

    // FIFO pointers, occupancy, registered head and overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            outp_r      <= {DW{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {CW{1'b0}});
            outp_r      <= head_nxt_s;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign outp      = outp_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Scoreboard bench: three decimator configurations share one randomized stream and are
// each checked against a queue-based reference model.
module tb_fir_decim_fifo;

    localparam int DEPTH = 8;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic [7:0] inp       = 8'h00;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_ovf   = 1'b0;

    logic [7:0] outp_a      [3];
    logic       out_valid_a [3];
    logic [3:0] count_a     [3];
    logic       ovf_a       [3];
    logic [7:0] logq        [3][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Instance 0: keep-first DECIM=4; instance 1: average DECIM=4; instance 2: keep-first DECIM=2
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int DEC = (g == 2) ? 2 : 4;
        localparam int MD  = (g == 1) ? 1 : 0;

        fir_decim_fifo #(.DW(8), .DECIM(DEC), .MODE(MD), .DEPTH(DEPTH)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .inp       (inp),
            .in_valid  (in_valid),
            .outp      (outp_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready),
            .count     (count_a[g]),
            .ovf       (ovf_a[g]),
            .clr_ovf   (clr_ovf)
        );

        int         grp [$];
        logic [7:0] mq  [$];
        logic [7:0] expq[$];
        logic       movf = 1'b0;

        // Reference model: groups of samples, FIFO as a queue, plain integer averaging
        initial forever begin : model
            logic       pop;
            logic       dec;
            logic       drop;
            logic [7:0] dval;
            int         s;
            int         q;
            @(posedge clk or negedge rst);
            if (!rst) begin
                grp.delete();
                mq.delete();
                expq.delete();
                movf = 1'b0;
            end else begin
                pop  = (mq.size() != 0) && out_ready;
                dec  = 1'b0;
                drop = 1'b0;
                dval = 8'h00;
                if (in_valid) begin
                    grp.push_back(int'($signed(inp)));
                    if (MD == 0) begin
                        if (grp.size() == 1) begin
                            dec  = 1'b1;
                            dval = inp;
                        end
                    end else if (grp.size() == DEC) begin
                        s = 0;
                        foreach (grp[i]) s += grp[i];
                        q = s / DEC;
                        if ((s % DEC != 0) && (s < 0)) q = q - 1;
                        dec  = 1'b1;
                        dval = q[7:0];
                    end
                    if (grp.size() == DEC) grp.delete();
                end
                if (pop) void'(mq.pop_front());
                if (dec) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(dval);
                        expq.push_back(dval);
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (drop) movf = 1'b1;
                else if (clr_ovf) movf = 1'b0;
            end
        end

        // Monitor: status every cycle, data on every accepted output
        initial forever begin : mon
            logic [7:0] e;
            @(negedge clk);
            check($sformatf("g%0d count", g), int'(count_a[g]), mq.size());
            check($sformatf("g%0d out_valid", g), int'(out_valid_a[g]), (mq.size() != 0) ? 1 : 0);
            check($sformatf("g%0d ovf", g), int'(ovf_a[g]), int'(movf));
            if (out_valid_a[g] && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL g%0d unexpected output: got %0d expected none", g, outp_a[g]);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("g%0d outp", g), int'(outp_a[g]), int'(e));
                    logq[g].push_back(outp_a[g]);
                end
            end
        end
    end

    task automatic cyc(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
        in_valid  = iv;
        inp       = d;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse with junk stimulus that must be ignored
    task automatic pulse_reset();
        rst       = 1'b0;
        in_valid  = 1'b1;
        inp       = 8'h7E;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("g%0d rst count", i), int'(count_a[i]), 0);
            check($sformatf("g%0d rst out_valid", i), int'(out_valid_a[i]), 0);
            logq[i].delete();
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    logic [7:0] v31 [8] = '{8'h92, 8'h40, 8'h04, 8'h31, 8'h86, 8'hC6, 8'h32, 8'h09};
    logic [7:0] v32 [4] = '{8'h40, 8'h04, 8'h31, 8'h86};
    logic [7:0] d33 [18];

    initial begin
        int rdy_pct;
        in_valid  = 1'b1;
        inp       = 8'hA5;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("g%0d init outp", i), int'(outp_a[i]), 0);
            check($sformatf("g%0d init out_valid", i), int'(out_valid_a[i]), 0);
            check($sformatf("g%0d init count", i), int'(count_a[i]), 0);
            check($sformatf("g%0d init ovf", i), int'(ovf_a[i]), 0);
        end
        rst      = 1'b1;
        in_valid = 1'b0;

        // Keep-first vector
        for (int i = 0; i < 8; i++) cyc(1'b1, v31[i], 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("mode0 output count", logq[0].size(), 2);
        if (logq[0].size() == 2) begin
            check("mode0 first", int'(logq[0][0]), 'h92);
            check("mode0 second", int'(logq[0][1]), 'h86);
        end

        // Averaging vector, sum -5 floors to -2
        pulse_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, v32[i], 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("mode1 output count", logq[1].size(), 1);
        if (logq[1].size() == 1) check("mode1 average", int'(logq[1][0]), 'hFE);

        // Fill to overflow, clear/drop race, full push+pop, drain in order
        pulse_reset();
        for (int i = 0; i < 18; i++) begin
            d33[i] = 8'($urandom);
            cyc(1'b1, d33[i], 1'b0, 1'b0);
        end
        check("full count", int'(count_a[2]), 8);
        check("full ovf", int'(ovf_a[2]), 1);
        cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
        check("clr with drop ovf", int'(ovf_a[2]), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr alone ovf", int'(ovf_a[2]), 0);
        cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
        check("full push+pop count", int'(count_a[2]), 8);
        check("full push+pop ovf", int'(ovf_a[2]), 0);
        repeat (12) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("drained count", int'(count_a[2]), 0);
        check("drained outputs", logq[2].size(), 9);
        if (logq[2].size() == 9) begin
            for (int k = 0; k < 8; k++) check($sformatf("readback %0d", k), int'(logq[2][k]), int'(d33[2*k]));
        end

        // Reset mid-group with three queued entries
        pulse_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("pre-reset count", int'(count_a[2]), 3);
        pulse_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic with varying back-pressure
        rdy_pct = 90;
        for (int n = 0; n < 800; n++) begin
            if (n % 50 == 0) rdy_pct = (n % 150 == 0) ? 0 : ((n % 100 == 0) ? 30 : 90);
            if (n == 400) pulse_reset();
            cyc(($urandom_range(0, 3) != 0), 8'($urandom),
                ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 15) == 0));
        end
        repeat (20) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
